irs_event_framer: RTL
=====================

IRS_EVENT_FRAMER -- requirements
Module: irs_event_framer

Interface
REQ-001 Parameter HEADER_MAGIC, default 16'hA5E0, is the first word of every event frame.
REQ-002 Parameter TRAILER_MAGIC, default 16'h5AE1, is the last word of every event frame.
REQ-003 Parameter BUF_DEPTH_LOG2, default 4, sets holding-buffer depth to 2^BUF_DEPTH_LOG2 entries.
REQ-004 Port clk_i, input, 1 bit, the single block clock.
REQ-005 Port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 Port event_dat_i, input, 16 bits, DMA data word.
REQ-007 Port event_wr_i, input, 1 bit, qualifies event_dat_i; cannot be stalled.
REQ-008 Port active_i, input, 1 bit, DMA-active flag; high for the whole event.
REQ-009 Port fifo_dat_o, output, 16 bits, word to the event FIFO.
REQ-010 Port fifo_wr_o, output, 1 bit, event-FIFO write strobe.
REQ-011 Port fifo_full_i, input, 1 bit, event FIFO full.
REQ-012 Port event_count_o, output, 16 bits, current event number.
REQ-013 Port overflow_o, output, 1 bit, sticky flag: a data word was dropped.
REQ-014 Port busy_o, output, 1 bit, high while a frame is in progress or the buffer is non-empty.
REQ-015 Port debug_o, output, 32 bits: [2:0] state, [7:3] buffer count, [8] overflow, [9] fifo_full_i, [31:16] fifo_dat_o.

Function
REQ-016 Input stage pushes 17-bit entries to the buffer: bit16=0 is data; bit16=1 is a marker (bit0=0 start, bit0=1 end).
REQ-017 A rising edge of active_i pushes a start marker; event_wr_i is registered once, then pushed as data one cycle later.
REQ-018 The end marker is pushed two cycles after the falling edge of active_i, after the last data word.
REQ-019 Data has push priority; a coincident marker is held in a pending bit and pushed in the next free cycle.
REQ-020 Data is dropped when buffer count >= depth-2: set overflow_o and the frame's drop flag. Markers are accepted while count < depth.
REQ-021 FSM states: IDLE, HDR0, HDR1, DATA, TRL0, TRL1, TRL2.
REQ-022 IDLE: on a start marker at buffer head, pop it -> HDR0. Any other entry in IDLE is popped and discarded.
REQ-023 HDR0 emits HEADER_MAGIC; HDR1 emits event_count_o.
REQ-024 DATA: pop and emit data entries; on an end marker, pop it -> TRL0. A start marker in DATA -> TRL0 without popping it.
REQ-025 TRL0 emits {drop_flag, 15-bit count of data words emitted}. The count saturates at 7FFF.
REQ-026 TRL1 emits the checksum (see REQ-033); TRL2 emits TRAILER_MAGIC, then event_count_o increments (FFFF wraps to 0000) -> IDLE.
REQ-027 fifo_wr_o is combinational: state emits a word AND !fifo_full_i. The state/pop advances only on fifo_wr_o; full stalls indefinitely with no word lost or duplicated.
REQ-028 Data latency: event_wr_i to fifo_wr_o is at least 2 cycles with an empty buffer and FIFO not full.

Reset
REQ-029 rst_i clears the FSM to IDLE, the buffer, pending bits, drop flag, word count and checksum.
REQ-030 After reset: fifo_wr_o=0, fifo_dat_o=0, event_count_o=0, overflow_o=0, busy_o=0.
REQ-031 Reset mid-frame abandons the partial frame with no trailer; the next frame starts at event 0.
REQ-032 overflow_o clears only on reset.

Configuration
REQ-033 With EVENT_CHECKSUM_EN defined: TRL1 emits the XOR of all emitted data words (frame is 5+N words). Without it: TRL1 does not exist, TRL0 -> TRL2 (frame is 4+N words).

Structure
REQ-034 Shared package irs_event_pkg holds: state encoding, marker bit positions and codes, default magic constants.
REQ-035 Sub-module event_framer_fifo: 17-bit first-word-fall-through synchronous FIFO; outputs count, empty and full.

Verification
REQ-036 Reset, then active_i high 1 cycle before 4 words 0001..0004, active_i falls with the last word -> A5E0,0000,0001,0002,0003,0004,0004,0004,5AE1; event_count_o=1.
REQ-037 Same event without EVENT_CHECKSUM_EN -> A5E0,0000,0001..0004,0004,5AE1 (8 words).
REQ-038 fifo_full_i held high 20 cycles mid-event, 10 words in -> output order intact, no overflow.
REQ-039 fifo_full_i held high through 16 input words, depth 16 -> overflow_o=1, TRL0 bit15=1, count = words emitted.
REQ-040 Two back-to-back events with 3-cycle active_i gap -> two complete frames, event numbers 0000 then 0001.
REQ-041 rst_i mid-DATA, then a new 2-word event -> single frame with event number 0000, no stale words emitted.

Source files
------------

// File: rtl/irs_event_pkg.sv
// Shared definitions for the IRS event framer: FSM state encoding, buffer entry/marker layout, default magics.
package irs_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_TRL0 = 3'd4,
    ST_TRL1 = 3'd5,
    ST_TRL2 = 3'd6
  } state_e;

  localparam int ENTRY_W     = 17;
  localparam int MK_BIT      = 16;
  localparam int MK_CODE_BIT = 0;
  localparam int MK_DROP_BIT = 1;
  localparam logic MK_START  = 1'b0;
  localparam logic MK_END    = 1'b1;

  localparam logic [15:0] DEF_HEADER_MAGIC  = 16'hA5E0;
  localparam logic [15:0] DEF_TRAILER_MAGIC = 16'h5AE1;

  // End markers carry the frame's drop flag so it travels in order with the data.
  function automatic logic [ENTRY_W-1:0] mk_marker(input logic code, input logic drop);
    logic [ENTRY_W-1:0] m;
    m              = '0;
    m[MK_BIT]      = 1'b1;
    m[MK_CODE_BIT] = code;
    m[MK_DROP_BIT] = drop;
    return m;
  endfunction

endpackage

// File: rtl/event_framer_fifo.sv
// First-word-fall-through synchronous FIFO; head valid the cycle after push.
// Pushes while full and pops while empty are ignored.
module event_framer_fifo #(
  parameter int W = 17,
  parameter int L = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [L:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int DEPTH = 1 << L;

  logic [W-1:0] r_mem [DEPTH];
  logic [L-1:0] r_wptr;
  logic [L-1:0] r_rptr;
  logic [L:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign full_o    = (r_count == (L+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign head_o    = r_mem[r_rptr];
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + L'(1);
      if (w_do_pop)  r_rptr <= r_rptr + L'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (L+1)'(1);
        2'b01:   r_count <= r_count - (L+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= push_dat_i;
  end

endmodule

// File: rtl/irs_event_framer.sv
// Frames DMA event words as header/number/data/trailer into the event FIFO; data latency >= 2 cycles.
// fifo_full_i stalls framing losslessly; input cannot stall, so data is dropped when the buffer nears full. Define EVENT_CHECKSUM_EN to add the XOR checksum word.
module irs_event_framer
  import irs_event_pkg::*;
#(
  parameter logic [15:0] HEADER_MAGIC   = DEF_HEADER_MAGIC,
  parameter logic [15:0] TRAILER_MAGIC  = DEF_TRAILER_MAGIC,
  parameter int          BUF_DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] event_dat_i,
  input  logic        event_wr_i,
  input  logic        active_i,
  output logic [15:0] fifo_dat_o,
  output logic        fifo_wr_o,
  input  logic        fifo_full_i,
  output logic [15:0] event_count_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic [31:0] debug_o
);

  localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int CW    = BUF_DEPTH_LOG2 + 1;

  logic               r_active_d, r_wr_d, r_fall_d1, r_fall_d2;
  logic               r_start_pend, r_end_pend, r_in_drop, r_overflow;
  logic [15:0]        r_dat_d;
  logic               w_rise, w_fall, w_start_req, w_end_req;
  logic               w_data_ok, w_drop, w_free, w_start_push, w_end_push, w_push;
  logic [ENTRY_W-1:0] w_push_dat, w_head;
  logic [CW-1:0]      w_count;
  logic               w_empty, w_full, w_pop;

  state_e             r_state, w_next;
  logic [15:0]        r_event_count;
  logic [14:0]        r_wcount;
  logic               r_drop;
  logic               w_emit, w_data_emit, w_head_mk, w_head_end;
  logic [15:0]        w_word;
`ifdef EVENT_CHECKSUM_EN
  logic [15:0]        r_csum;
`endif

  assign w_rise       = active_i & ~r_active_d;
  assign w_fall       = ~active_i & r_active_d;
  assign w_start_req  = w_rise | r_start_pend;
  assign w_end_req    = r_fall_d2 | r_end_pend;
  assign w_data_ok    = r_wr_d & (w_count < CW'(DEPTH - 2));
  assign w_drop       = r_wr_d & ~w_data_ok;
  // A dropped word leaves the push slot free for a waiting marker.
  assign w_free       = ~w_data_ok & ~w_full;
  assign w_end_push   = w_end_req & w_free;
  assign w_start_push = w_start_req & w_free & ~w_end_req;
  assign w_push       = w_data_ok | w_end_push | w_start_push;

  always_comb begin
    w_push_dat = mk_marker(MK_START, 1'b0);
    if (w_data_ok)       w_push_dat = {1'b0, r_dat_d};
    else if (w_end_push) w_push_dat = mk_marker(MK_END, r_in_drop | w_drop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active_d   <= 1'b0;
      r_wr_d       <= 1'b0;
      r_dat_d      <= '0;
      r_fall_d1    <= 1'b0;
      r_fall_d2    <= 1'b0;
      r_start_pend <= 1'b0;
      r_end_pend   <= 1'b0;
      r_in_drop    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_active_d   <= active_i;
      r_wr_d       <= event_wr_i;
      r_dat_d      <= event_dat_i;
      r_fall_d1    <= w_fall;
      r_fall_d2    <= r_fall_d1;
      r_start_pend <= w_start_req & ~w_start_push;
      r_end_pend   <= w_end_req & ~w_end_push;
      if (w_start_push | w_end_push) r_in_drop <= 1'b0;
      else if (w_drop)               r_in_drop <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  event_framer_fifo #(
    .W (ENTRY_W),
    .L (BUF_DEPTH_LOG2)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_push),
    .push_dat_i (w_push_dat),
    .pop_i      (w_pop),
    .head_o     (w_head),
    .count_o    (w_count),
    .empty_o    (w_empty),
    .full_o     (w_full)
  );

  assign w_head_mk  = w_head[MK_BIT];
  assign w_head_end = (w_head[MK_CODE_BIT] == MK_END);

  always_comb begin
    w_next      = r_state;
    w_emit      = 1'b0;
    w_word      = '0;
    w_pop       = 1'b0;
    w_data_emit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_mk && !w_head_end) w_next = ST_HDR0;
        end
      end
      ST_HDR0: begin
        w_emit = 1'b1;
        w_word = HEADER_MAGIC;
        if (!fifo_full_i) w_next = ST_HDR1;
      end
      ST_HDR1: begin
        w_emit = 1'b1;
        w_word = r_event_count;
        if (!fifo_full_i) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (!w_empty) begin
          if (!w_head_mk) begin
            w_emit = 1'b1;
            w_word = w_head[15:0];
            if (!fifo_full_i) begin
              w_pop       = 1'b1;
              w_data_emit = 1'b1;
            end
          end else if (w_head_end) begin
            w_pop  = 1'b1;
            w_next = ST_TRL0;
          end else begin
            // Missing end marker: close this frame, leave the start for IDLE.
            w_next = ST_TRL0;
          end
        end
      end
      ST_TRL0: begin
        w_emit = 1'b1;
        w_word = {r_drop, r_wcount};
`ifdef EVENT_CHECKSUM_EN
        if (!fifo_full_i) w_next = ST_TRL1;
`else
        if (!fifo_full_i) w_next = ST_TRL2;
`endif
      end
`ifdef EVENT_CHECKSUM_EN
      ST_TRL1: begin
        w_emit = 1'b1;
        w_word = r_csum;
        if (!fifo_full_i) w_next = ST_TRL2;
      end
`endif
      ST_TRL2: begin
        w_emit = 1'b1;
        w_word = TRAILER_MAGIC;
        if (!fifo_full_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_event_count <= '0;
      r_wcount      <= '0;
      r_drop        <= 1'b0;
`ifdef EVENT_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_HDR0) begin
        r_wcount <= '0;
        r_drop   <= 1'b0;
`ifdef EVENT_CHECKSUM_EN
        r_csum   <= '0;
`endif
      end
      if (w_data_emit) begin
        if (r_wcount != 15'h7FFF) r_wcount <= r_wcount + 15'd1;
`ifdef EVENT_CHECKSUM_EN
        r_csum <= r_csum ^ w_head[15:0];
`endif
      end
      if (r_state == ST_DATA && w_pop && w_head_mk) r_drop <= w_head[MK_DROP_BIT];
      if (r_state == ST_TRL2 && fifo_wr_o) r_event_count <= r_event_count + 16'd1;
    end
  end

  assign fifo_wr_o     = w_emit & ~fifo_full_i;
  assign fifo_dat_o    = w_word;
  assign event_count_o = r_event_count;
  assign overflow_o    = r_overflow;
  assign busy_o        = (r_state != ST_IDLE) | ~w_empty | r_start_pend | r_end_pend;
  assign debug_o       = {fifo_dat_o, 6'd0, fifo_full_i, r_overflow, 5'(w_count), r_state};

endmodule
